// File: rtl/race_scoreboard_pkg.sv
// rtl/race_scoreboard_pkg.sv - shared status, light and glyph definitions for the race scoreboard
package race_scoreboard_pkg;

   localparam logic [3:0] ST_RACING = 4'b1000;
   localparam logic [3:0] ST_PLACE1 = 4'b1001;
   localparam int         ST_OK_BIT = 3;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   typedef enum logic [1:0] {
      LT_GREEN = 2'b00,
      LT_AMBER = 2'b01,
      LT_RED   = 2'b10,
      LT_RSVD  = 2'b11
   } light_e;

   typedef struct packed {
      logic       vld;
      logic [3:0] pos;
      logic [3:0] st;
   } slot_t;

   // The reserved code falls back to green so the LEDs always show a legal state.
   function automatic logic [2:0] light_led(input logic [1:0] code);
      case (code)
         LT_RED:            light_led = 3'b100;
         LT_AMBER:          light_led = 3'b010;
         LT_GREEN, LT_RSVD: light_led = 3'b001;
         default:           light_led = 3'b001;
      endcase
   endfunction

endpackage

// File: rtl/race_scoreboard_if.sv
// rtl/race_scoreboard_if.sv - time-multiplexed status stream from the game core
interface race_scoreboard_if;

   logic [1:0] player_sel;
   logic [3:0] position;
   logic [3:0] status_code;
   logic [1:0] red_light;

   modport master (output player_sel, output position, output status_code, output red_light);
   modport slave  (input  player_sel, input  position, input  status_code, input  red_light);

endinterface

// File: rtl/race_scoreboard_seg7_decode.sv
// rtl/race_scoreboard_seg7_decode.sv - 4-bit hex to active-low {g..a} seven-segment glyph
module seg7_decode
   import race_scoreboard_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (hex)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/race_scoreboard.sv
// rtl/race_scoreboard.sv - demultiplexes the race status stream into four slots and drives display, lights and game-over flags
module race_scoreboard
   import race_scoreboard_pkg::*;
#(
   parameter logic [15:0] REFRESH_DIV = 16'd50000,
   parameter int          BLINK_BIT   = 23
) (
   input  logic              clk,
   input  logic              rst,
   race_scoreboard_if.slave  stream,
   output logic [6:0]        out_seg,
   output logic              out_dp,
   output logic [3:0]        out_an,
   output logic [2:0]        out_light,
   output logic              out_game_over,
   output logic [1:0]        out_winner,
   output logic              out_winner_vld
);

   slot_t            slots    [4];
   slot_t            slots_nx [4];
   logic [1:0]       prev_sel;
   logic [15:0]      refresh_cnt;
   logic [1:0]       digit_idx;
   logic [BLINK_BIT:0] blink_cnt;

   logic             cap_en;
   logic [1:0]       cap_idx;
   logic             all_vld;
   logic             any_racing;
   logic             win_vld_nx;
   logic [1:0]       win_nx;

   slot_t            cur;
   logic [3:0]       dec_hex;
   logic [6:0]       dec_seg;
   logic [6:0]       digit_seg;
   logic             digit_dp;
   logic             blank;

   // The data word trails its tag by one slot, so a tag change lands in slot (sel-1).
   always_comb begin
      cap_en     = (stream.player_sel != prev_sel);
      cap_idx    = stream.player_sel - 2'd1;
      all_vld    = 1'b1;
      any_racing = 1'b0;
      win_vld_nx = 1'b0;
      win_nx     = 2'd0;
      for (int i = 0; i < 4; i++) begin
         slots_nx[i] = slots[i];
         if (cap_en && (cap_idx == 2'(i))) begin
            slots_nx[i].vld = 1'b1;
            slots_nx[i].pos = stream.position;
            slots_nx[i].st  = stream.status_code;
         end
         all_vld    = all_vld & slots_nx[i].vld;
         any_racing = any_racing | (slots_nx[i].vld && (slots_nx[i].st == ST_RACING));
      end
      for (int i = 3; i >= 0; i--) begin
         if (slots_nx[i].vld && (slots_nx[i].st == ST_PLACE1)) begin
            win_vld_nx = 1'b1;
            win_nx     = 2'(i);
         end
      end
   end

   assign cur     = slots[digit_idx];
   assign dec_hex = (cur.st == ST_RACING) ? cur.pos : {1'b0, cur.st[2:0]};

   seg7_decode u_dec (
      .hex (dec_hex),
      .seg (dec_seg)
   );

   always_comb begin
      digit_seg = SEG_BLANK;
      digit_dp  = 1'b1;
      if (cur.vld) begin
         if (!cur.st[ST_OK_BIT]) begin
            digit_seg = SEG_DASH;
         end else begin
            digit_seg = dec_seg;
            digit_dp  = (cur.st == ST_RACING);
         end
      end
   end

   assign blank = out_game_over && blink_cnt[BLINK_BIT] &&
                  !(out_winner_vld && (out_winner == digit_idx));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) slots[i] <= '0;
         prev_sel       <= 2'd0;
         refresh_cnt    <= 16'd0;
         digit_idx      <= 2'd0;
         blink_cnt      <= '0;
         out_seg        <= SEG_BLANK;
         out_dp         <= 1'b1;
         out_an         <= 4'hF;
         out_light      <= 3'b000;
         out_game_over  <= 1'b0;
         out_winner     <= 2'd0;
         out_winner_vld <= 1'b0;
      end else begin
         prev_sel  <= stream.player_sel;
         slots     <= slots_nx;
         blink_cnt <= blink_cnt + 1'b1;
         if (refresh_cnt == REFRESH_DIV - 16'd1) begin
            refresh_cnt <= 16'd0;
            digit_idx   <= digit_idx + 2'd1;
         end else begin
            refresh_cnt <= refresh_cnt + 16'd1;
         end
         out_light      <= light_led(stream.red_light);
         out_game_over  <= all_vld && !any_racing;
         out_winner     <= win_nx;
         out_winner_vld <= win_vld_nx;
         if (blank) begin
            out_an  <= 4'hF;
            out_seg <= SEG_BLANK;
            out_dp  <= 1'b1;
         end else begin
            out_an  <= ~(4'b0001 << digit_idx);
            out_seg <= digit_seg;
            out_dp  <= digit_dp;
         end
      end
   end

endmodule

// File: tb/tb_race_scoreboard.sv
// tb/tb_race_scoreboard.sv - scoreboard bench for race_scoreboard
module tb_race_scoreboard;

   localparam int K_ALL   = 0;
   localparam int K_DISP  = 1;
   localparam int K_LIGHT = 2;
   localparam int K_GO    = 3;
   localparam int K_WIN   = 4;
   localparam int K_AN    = 5;

   localparam logic [18:0] RST_EXP = {7'h7F, 1'b1, 4'hF, 3'b000, 1'b0, 2'b00, 1'b0};

   typedef struct {
      int          kind;
      bit          wait_an;
      logic [3:0]  an;
      logic [18:0] exp;
      string       name;
   } chk_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] out_seg;
   logic       out_dp;
   logic [3:0] out_an;
   logic [2:0] out_light;
   logic       out_game_over;
   logic [1:0] out_winner;
   logic       out_winner_vld;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   chk_t q[$];

   race_scoreboard_if sif ();

   race_scoreboard #(
      .REFRESH_DIV (16'd4),
      .BLINK_BIT   (3)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stream         (sif),
      .out_seg        (out_seg),
      .out_dp         (out_dp),
      .out_an         (out_an),
      .out_light      (out_light),
      .out_game_over  (out_game_over),
      .out_winner     (out_winner),
      .out_winner_vld (out_winner_vld)
   );

   always #5 clk = ~clk;

   // Cycles since reset release; mirrors where the free-running counters must be.
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   function automatic logic [18:0] sample(input int kind);
      case (kind)
         K_ALL:   sample = {out_seg, out_dp, out_an, out_light, out_game_over, out_winner, out_winner_vld};
         K_DISP:  sample = {11'd0, out_dp, out_seg};
         K_LIGHT: sample = {16'd0, out_light};
         K_GO:    sample = {18'd0, out_game_over};
         K_WIN:   sample = {16'd0, out_winner_vld, out_winner};
         default: sample = {15'd0, out_an};
      endcase
   endfunction

   task automatic push(input int kind, input bit wait_an, input logic [3:0] an,
                       input logic [18:0] exp, input string name);
      chk_t c;
      c.kind    = kind;
      c.wait_an = wait_an;
      c.an      = an;
      c.exp     = exp;
      c.name    = name;
      q.push_back(c);
   endtask

   task automatic push_disp(input int d, input logic [7:0] dp_seg, input string name);
      logic [3:0] an;
      an = ~(4'b0001 << d);
      push(K_DISP, 1'b1, an, {11'd0, dp_seg}, name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic drive(input logic [1:0] s, input logic [3:0] p, input logic [3:0] c);
      sif.player_sel  = s;
      sif.position    = p;
      sif.status_code = c;
      tick();
   endtask

   task automatic wait_for_an(input logic [3:0] a, input bit need_edge, input string name);
      int         n;
      bit         found;
      logic [3:0] prev;
      n     = 0;
      found = 1'b0;
      while (n < 64 && !found) begin
         prev = out_an;
         tick();
         n++;
         if (out_an == a && (!need_edge || prev != a)) found = 1'b1;
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL %s: out_an never reached %h (last %h)", name, a, out_an);
      end
   endtask

   initial begin : monitor
      chk_t       c;
      logic [18:0] act;
      int         waited;
      bit         done;
      waited = 0;
      forever begin
         @(negedge clk);
         done = 1'b0;
         while (!done && q.size() > 0) begin
            c = q[0];
            if (!c.wait_an || out_an == c.an) begin
               act = sample(c.kind);
               checks++;
               if (act !== c.exp) begin
                  errors++;
                  $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
               end
               void'(q.pop_front());
               waited = 0;
            end else begin
               waited++;
               if (waited > 64) begin
                  checks++;
                  errors++;
                  $display("FAIL %s: digit enable %h never seen, out_an %h", c.name, c.an, out_an);
                  void'(q.pop_front());
                  waited = 0;
               end
               done = 1'b1;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic [3:0] an_seq [4];
      logic [3:0] exp_an;
      int         c;
      int         d;
      an_seq[0] = 4'hE;
      an_seq[1] = 4'hD;
      an_seq[2] = 4'hB;
      an_seq[3] = 4'h7;

      rst             = 1'b1;
      sif.player_sel  = 2'd0;
      sif.position    = 4'd0;
      sif.status_code = 4'd0;
      sif.red_light   = 2'b00;

      for (int i = 0; i < 3; i++) begin
         tick();
         push(K_ALL, 1'b0, 4'h0, RST_EXP, "reset_hold");
      end
      rst = 1'b0;
      tick();
      push(K_LIGHT, 1'b0, 4'h0, 19'(3'b001), "light_green_after_reset");
      for (int i = 0; i < 4; i++) push_disp(i, 8'hFF, "blank_after_reset");
      drain();

      drive(2'd1, 4'd5, 4'b1000);
      push(K_GO,  1'b0, 4'h0, 19'd0, "go_slot0_racing");
      push(K_WIN, 1'b0, 4'h0, 19'd0, "no_winner_yet");
      tick();
      push_disp(0, 8'h92, "digit0_pos5");
      drain();

      drive(2'd3, 4'd0, 4'b1001);
      push(K_WIN, 1'b0, 4'h0, 19'(3'b110), "winner_slot2");
      push(K_GO,  1'b0, 4'h0, 19'd0, "go_after_place1");
      tick();
      push_disp(2, 8'h79, "digit2_place1_dp");
      drain();

      drive(2'd0, 4'd7, 4'b0000);
      push(K_GO,  1'b0, 4'h0, 19'd0, "go_slot1_invalid");
      push(K_WIN, 1'b0, 4'h0, 19'(3'b110), "winner_kept");
      tick();
      push_disp(3, 8'hBF, "digit3_dash");
      drain();

      wait_for_an(4'hE, 1'b1, "scan_sync");
      push(K_AN, 1'b0, 4'h0, 19'(4'hE), "scan_walk");
      for (int k = 1; k <= 16; k++) begin
         tick();
         push(K_AN, 1'b0, 4'h0, 19'(an_seq[(k / 4) % 4]), "scan_walk");
      end
      drain();

      drive(2'd1, 4'd2, 4'b1010);
      push(K_GO, 1'b0, 4'h0, 19'd0, "go_still_missing_slot1");
      drain();

      drive(2'd2, 4'd9, 4'b1011);
      push(K_GO,  1'b0, 4'h0, 19'd1, "game_over_set");
      push(K_WIN, 1'b0, 4'h0, 19'(3'b110), "winner_at_game_over");
      drain();

      for (int k = 0; k < 24; k++) begin
         tick();
         c = cyc - 1;
         d = (c >> 2) & 3;
         exp_an = ~(4'b0001 << d);
         if (((c >> 3) & 1) == 1 && d != 2) exp_an = 4'hF;
         push(K_AN, 1'b0, 4'h0, 19'(exp_an), "blink_an");
      end
      push_disp(2, 8'h79, "winner_digit_visible");
      drain();

      drive(2'd3, 4'd0, 4'b1001);
      push(K_GO, 1'b0, 4'h0, 19'd1, "game_over_holds");
      drain();

      drive(2'd2, 4'd4, 4'b1000);
      push(K_GO,  1'b0, 4'h0, 19'd0, "game_over_drops");
      push(K_WIN, 1'b0, 4'h0, 19'(3'b110), "winner_after_drop");
      tick();
      push_disp(1, 8'h99, "digit1_pos4");
      push_disp(0, 8'h24, "digit0_place2_dp");
      drain();

      sif.red_light = 2'b10;
      tick();
      push(K_LIGHT, 1'b0, 4'h0, 19'(3'b100), "light_red");
      sif.red_light = 2'b11;
      tick();
      push(K_LIGHT, 1'b0, 4'h0, 19'(3'b001), "light_reserved");
      sif.red_light = 2'b01;
      tick();
      push(K_LIGHT, 1'b0, 4'h0, 19'(3'b010), "light_amber");
      drain();

      wait_for_an(4'hB, 1'b0, "reset_sync");
      rst = 1'b1;
      tick();
      push(K_ALL, 1'b0, 4'h0, RST_EXP, "reset_mid_scan");
      drain();
      rst = 1'b0;
      tick();
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
